// File: rtl/sig_meas_mc_if.sv
// sig_meas_mc_if: ADC sample input and measurement result bundle for sig_meas_mc
interface sig_meas_mc_if #(
   parameter int CH_NUM = 2,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 24
);
   logic [CH_NUM*DATA_W-1:0] ad_data;
   logic                     meas_en;
   logic [CH_NUM*CNT_W-1:0]  period;
   logic [CH_NUM*CNT_W-1:0]  high_time;
   logic [CH_NUM*DATA_W-1:0] peak;
   logic [CH_NUM*CNT_W-1:0]  phase_dly;
   logic [CH_NUM-1:0]        ch_valid;
   logic                     upd_vld;
   modport master (output ad_data, meas_en, input period, high_time, peak, phase_dly, ch_valid, upd_vld);
   modport slave  (input ad_data, meas_en, output period, high_time, peak, phase_dly, ch_valid, upd_vld);
endinterface

// File: rtl/sig_meas_mc.sv
// sig_meas_mc: multi-channel Schmitt-edge period/high-time/peak/phase measurement with periodic snapshots
module sig_meas_mc #(
   parameter int CH_NUM     = 2,
   parameter int DATA_W     = 16,
   parameter int CNT_W      = 24,
   parameter int MEDIAN     = 32767,
   parameter int HYST       = 15,
   parameter int HOLD_CYC   = 3,
   parameter int TIMEOUT    = 16777215,
   parameter int UPD_CYCLES = 59000000
) (
   input logic          sys_clk,
   input logic          sys_rst,
   sig_meas_mc_if.slave meas_io
);
   localparam int LK_W = $clog2(HOLD_CYC + 2);
   localparam int UP_W = UPD_CYCLES > 1 ? $clog2(UPD_CYCLES) : 1;
   localparam int DW1 = DATA_W + 1;
   localparam logic [DATA_W:0] HI_TH = DW1'(MEDIAN + HYST);
   localparam logic [DATA_W:0] LO_TH = DW1'(MEDIAN - HYST);
   localparam logic [DATA_W:0] MED = DW1'(MEDIAN);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   localparam logic [UP_W-1:0] LAST = UP_W'(UPD_CYCLES - 1);
   logic [UP_W-1:0]   snap_q, snap_d;
   logic              upd, upd_q;
   logic [CH_NUM-1:0] rise;
   assign upd = (snap_q == LAST) & meas_io.meas_en;
   assign snap_d = snap_q == LAST ? '0 : snap_q + UP_W'(1);
   assign meas_io.upd_vld = upd_q;
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
         snap_q <= '0;
         upd_q <= 1'b0;
      end else begin
         snap_q <= snap_d;
         upd_q <= upd;
      end
   for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
      logic [DATA_W:0]   smp;
      logic              lvl_q, lvl_d, seen_q, seen_d, ok_q, ok_d, arm_q, arm_d, vld_q, vld_d, tmo, in_band;
      logic [LK_W-1:0]   lk_q, lk_d;
      logic [CNT_W-1:0]  per_q, per_d, perl_q, perl_d, hic_q, hic_d, hil_q, hil_d;
      logic [CNT_W-1:0]  ph_q, ph_d, phl_q, phl_d, per_o_q, per_o_d, hi_o_q, hi_o_d, ph_o_q, ph_o_d;
      logic [DATA_W-1:0] mag, pk_max, pkr_q, pkr_d, pkl_q, pkl_d, pk_o_q, pk_o_d;
      assign smp = {1'b0, meas_io.ad_data[k*DATA_W +: DATA_W]};
      assign rise[k] = lvl_d & ~lvl_q & (lk_q == '0);
      always_comb begin
         in_band = !(smp > HI_TH || smp < LO_TH);
         lvl_d = smp > HI_TH ? 1'b1 : smp < LO_TH ? 1'b0 : lvl_q;
         mag = in_band ? '0 : DATA_W'(smp > MED ? smp - MED : MED - smp);
         pk_max = mag > pkr_q ? mag : pkr_q;
         tmo = per_q >= TMO;
         lk_d = rise[k] ? LK_W'(HOLD_CYC) : lk_q - LK_W'(lk_q != '0);
         pkr_d = rise[k] ? mag : pk_max;
         pkl_d = rise[k] ? pk_max : pkl_q;
         per_d = rise[k] ? ONE : per_q == CMAX ? per_q : per_q + ONE;
         perl_d = rise[k] ? per_q : perl_q;
         hic_d = rise[k] ? ONE : (lvl_d && hic_q != CMAX) ? hic_q + ONE : hic_q;
         hil_d = rise[k] ? hic_q : hil_q;
         // first rise after reset/timeout only arms; the second one validates
         seen_d = rise[k] ? 1'b1 : tmo ? 1'b0 : seen_q;
         ok_d = rise[k] ? seen_q & ~tmo : tmo ? 1'b0 : ok_q;
         arm_d = arm_q | rise[0];
         ph_d = rise[0] ? ONE : (arm_q && ph_q != CMAX) ? ph_q + ONE : ph_q;
         phl_d = (rise[0] && rise[k]) ? '0 : (rise[k] && arm_q) ? ph_q : phl_q;
         vld_d = upd ? ok_q : vld_q;
         per_o_d = upd ? (ok_q ? perl_q : '0) : per_o_q;
         hi_o_d = upd ? (ok_q ? hil_q : '0) : hi_o_q;
         pk_o_d = upd ? (ok_q ? pkl_q : '0) : pk_o_q;
         ph_o_d = upd ? ((ok_q && k != 0) ? phl_q : '0) : ph_o_q;
      end
      always_ff @(posedge sys_clk or posedge sys_rst)
         if (sys_rst) begin
            {lvl_q, seen_q, ok_q, arm_q, vld_q} <= '0;
            lk_q <= '0;
            {per_q, perl_q, hic_q, hil_q, ph_q, phl_q} <= '0;
            {per_o_q, hi_o_q, ph_o_q} <= '0;
            {pkr_q, pkl_q, pk_o_q} <= '0;
         end else begin
            {lvl_q, seen_q, ok_q, arm_q, vld_q} <= {lvl_d, seen_d, ok_d, arm_d, vld_d};
            lk_q <= lk_d;
            {per_q, perl_q, hic_q, hil_q, ph_q, phl_q} <= {per_d, perl_d, hic_d, hil_d, ph_d, phl_d};
            {per_o_q, hi_o_q, ph_o_q} <= {per_o_d, hi_o_d, ph_o_d};
            {pkr_q, pkl_q, pk_o_q} <= {pkr_d, pkl_d, pk_o_d};
         end
      assign meas_io.period[k*CNT_W +: CNT_W] = per_o_q;
      assign meas_io.high_time[k*CNT_W +: CNT_W] = hi_o_q;
      assign meas_io.phase_dly[k*CNT_W +: CNT_W] = ph_o_q;
      assign meas_io.peak[k*DATA_W +: DATA_W] = pk_o_q;
      assign meas_io.ch_valid[k] = vld_q;
   end
endmodule

// File: tb/tb_sig_meas_mc.sv
// tb_sig_meas_mc: directed waveforms with a snapshot scoreboard checked on every upd_vld
module tb_sig_meas_mc;
   localparam logic [15:0] HI = 16'd33767, LO = 16'd31767, FP = 16'd32777, FN = 16'd32757;
   typedef struct {
      logic [23:0] per, hi0, hi1, ph;
      logic [15:0] pk;
      logic [1:0]  v;
      int          gap;
   } exp_t;
   logic sys_clk = 1'b0, sys_rst = 1'b1;
   int total = 0, bad = 0;
   int wc = 0, dly = 25, mode = 0, cyc = 0, last = 0, nsnap = 0;
   bit glitch = 1'b0, last_ok = 1'b0;
   exp_t q[$];
   exp_t e;
   sig_meas_mc_if #(.CH_NUM(2), .DATA_W(16), .CNT_W(24)) mio ();
   sig_meas_mc #(.CH_NUM(2), .DATA_W(16), .CNT_W(24), .MEDIAN(32767), .HYST(15), .HOLD_CYC(3),
      .TIMEOUT(500), .UPD_CYCLES(1000)) dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .meas_io(mio));
   always #5 sys_clk = ~sys_clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, req);
      end
   endtask
   function automatic exp_t mk(input int h0, input int ph, input logic [1:0] v, input int gap);
      exp_t r;
      r.v = v;
      r.gap = gap;
      r.per = v != 0 ? 24'd100 : 24'd0;
      r.hi0 = v != 0 ? 24'(h0) : 24'd0;
      r.hi1 = v != 0 ? 24'd30 : 24'd0;
      r.pk = v != 0 ? 16'd1000 : 16'd0;
      r.ph = v != 0 ? 24'(ph) : 24'd0;
      return r;
   endfunction
   task automatic chk_out(input string tag, input exp_t x);
      chk({tag, " period0"}, 32'(mio.period[23:0]), 32'(x.per));
      chk({tag, " period1"}, 32'(mio.period[47:24]), 32'(x.per));
      chk({tag, " high0"}, 32'(mio.high_time[23:0]), 32'(x.hi0));
      chk({tag, " high1"}, 32'(mio.high_time[47:24]), 32'(x.hi1));
      chk({tag, " peak0"}, 32'(mio.peak[15:0]), 32'(x.pk));
      chk({tag, " peak1"}, 32'(mio.peak[31:16]), 32'(x.pk));
      chk({tag, " phase0"}, 32'(mio.phase_dly[23:0]), 32'd0);
      chk({tag, " phase1"}, 32'(mio.phase_dly[47:24]), 32'(x.ph));
      chk({tag, " ch_valid"}, 32'(mio.ch_valid), 32'(x.v));
   endtask
   task automatic drive();
      logic [15:0] c0, c1;
      if (mode == 0) begin
         c0 = wc[0] ? FP : FN;
         c1 = c0;
      end else begin
         c0 = (wc % 100) < 30 ? HI : LO;
         if (glitch && (wc % 100) == 2) c0 = LO;
         c1 = ((wc + 100 - dly) % 100) < 30 ? HI : LO;
      end
      mio.ad_data = {c1, c0};
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         drive();
         wc++;
         @(posedge sys_clk);
         #1;
      end
   endtask
   initial begin
      forever begin
         @(negedge sys_clk);
         cyc++;
         if (sys_rst) last_ok = 1'b0;
         if (mio.upd_vld === 1'b1) begin
            if (q.size() == 0) chk("unexpected upd_vld", 32'(mio.upd_vld), 32'd0);
            else begin
               e = q.pop_front();
               nsnap++;
               chk_out($sformatf("snap%0d", nsnap), e);
               if (e.gap != 0 && last_ok) chk($sformatf("snap%0d interval", nsnap), 32'(cyc - last), 32'(e.gap));
               last = cyc;
               last_ok = 1'b1;
            end
         end
      end
   end
   initial begin
      mio.meas_en = 1'b0;
      mio.ad_data = {FP, FP};
      repeat (3) @(posedge sys_clk);
      #1;
      chk_out("reset", mk(0, 0, 2'd0, 0));
      chk("reset upd_vld", 32'(mio.upd_vld), 32'd0);
      sys_rst = 1'b0;
      mode = 1;
      mio.meas_en = 1'b1;
      q.push_back(mk(30, 25, 2'd3, 0));
      run(1000);
      q.push_back(mk(30, 25, 2'd3, 1000));
      run(1000);
      dly = 0;
      q.push_back(mk(30, 0, 2'd3, 1000));
      run(1000);
      glitch = 1'b1;
      q.push_back(mk(29, 0, 2'd3, 1000));
      run(1000);
      glitch = 1'b0;
      dly = 25;
      mio.meas_en = 1'b0;
      run(2000);
      chk_out("frozen", mk(29, 0, 2'd3, 0));
      chk("frozen upd_vld", 32'(mio.upd_vld), 32'd0);
      mio.meas_en = 1'b1;
      q.push_back(mk(30, 25, 2'd3, 3000));
      run(1000);
      mode = 0;
      q.push_back(mk(0, 0, 2'd0, 1000));
      run(1000);
      mode = 1;
      q.push_back(mk(30, 25, 2'd3, 1000));
      run(1000);
      run(550);
      mode = 0;
      sys_rst = 1'b1;
      #1;
      chk_out("async reset", mk(0, 0, 2'd0, 0));
      chk("async reset upd_vld", 32'(mio.upd_vld), 32'd0);
      repeat (3) @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      q.push_back(mk(0, 0, 2'd0, 0));
      run(950);
      mode = 1;
      wc = 0;
      run(50);
      q.push_back(mk(30, 25, 2'd3, 1000));
      run(1000);
      run(5);
      chk("pending snapshots", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
